rom_burst_arbiter: RTL and testbench
====================================

// Module: rom_burst_arbiter
// PURPOSE
//  Shares one combinational 16x8 ROM (address[3:0] -> data[7:0]) between two requesters.
//  Each granted request is a burst of 1..16 sequential reads with address wrap-around.
//  Arbitration is round-robin. Read data is registered and streamed out with valid, last and requester-ID.
//  Sits between the ROM instance and its consumers; it is the sole driver of the ROM address.
// PARAMETERS
//  AW   4   ROM address width; burst length field is also AW bits
//  DW   8   ROM data width
// PORTS
//  clk       in   1   system clock, rising edge
//  rst_n     in   1   asynchronous active-low reset
//  req0      in   1   requester 0 burst request, level; held until gnt0
//  addr0     in   AW  requester 0 start address
//  len0      in   AW  requester 0 burst length minus 1 (0 -> 1 word, 15 -> 16 words)
//  req1      in   1   requester 1 burst request, level; held until gnt1
//  addr1     in   AW  requester 1 start address
//  len1      in   AW  requester 1 burst length minus 1
//  gnt0      out  1   one-cycle pulse: request 0 accepted, addr0/len0 captured
//  gnt1      out  1   one-cycle pulse: request 1 accepted, addr1/len1 captured
//  rom_addr  out  AW  address to ROM (registered)
//  rom_data  in   DW  data from ROM, combinational from rom_addr
//  rd_valid  out  1   rd_data holds a burst word this cycle
//  rd_data   out  DW  registered ROM word
//  rd_last   out  1   final word of the burst (qualified by rd_valid)
//  rd_id     out  1   requester owning the current rd_data word
//  busy      out  1   high while in BURST
// BEHAVIOUR
//  Reset (async, rst_n=0)
//   - All outputs are 0: gnt0, gnt1, rom_addr, rd_valid, rd_data, rd_last, rd_id, busy.
//   - State=IDLE. last_id=1, so req0 wins the first tie.
//   - Reset mid-burst aborts the burst immediately. No rd_last is produced.
//  FSM: IDLE, BURST. busy = (state==BURST).
//  IDLE, at each edge:
//   - If only one req is high, grant it. If both are high, grant the one != last_id.
//   - On grant: pulse gnt_x=1 for one cycle; rom_addr<=addr_x; cnt<=len_x; id<=x; last_id<=x; state<=BURST.
//   - With no req, outputs hold. rd_valid, rd_last and gnt are 0.
//  BURST, at each edge:
//   - rd_data<=rom_data; rd_valid<=1; rd_id<=id.
//   - rom_addr<=rom_addr+1, modulo 2^AW (15 wraps to 0).
//   - If cnt==0: rd_last<=1 and state<=IDLE. Otherwise cnt<=cnt-1 and rd_last<=0.
//   - Requests arriving during BURST are ignored until IDLE. No preemption.
//  Latency
//   - Edge E0 samples req and asserts gnt.
//   - First word is valid after E1, with rd_data=ROM[start].
//   - Word k is valid after E(k+1). Last word is valid after E(len+1).
//   - Back-to-back bursts: exactly one cycle with rd_valid=0 between last and next first word.
//  Handshake: requester deasserts req the cycle after gnt. A req still high in IDLE is a new request.
//  gnt0 and gnt1 are never high together. rd_valid is never high in IDLE except the last-word cycle.
// TESTING (bench ROM model: ROM[i] = 8'h10*i + i)
//  1. Reset, then req0 addr0=2 len0=0
//     -> gnt0 pulse; next cycle rd_valid=1, rd_data=8'h22, rd_last=1, rd_id=0; then busy=0.
//  2. req1 addr1=14 len1=3
//     -> rom_addr 14,15,0,1; rd_data EE,FF,00,11; rd_last only on the 4th beat; rd_id=1.
//  3. req0 and req1 held high continuously (len=1 each)
//     -> grants 0,1,0,1...; one-cycle rd_valid gap between bursts.
//  4. req1 raised during a len=15 burst of requester 0
//     -> no gnt1 until burst ends; gnt1 one cycle after rd_last.
//  5. rst_n=0 on the 5th beat of a 16-word burst
//     -> all outputs 0 asynchronously; after release, IDLE, busy=0, no rd_last.
//  6. req0 addr0=0 len0=15
//     -> 16 beats, rd_data = 00,11,...,FF, rd_last on beat 16; scoreboard matches the ROM model.

Source files
------------

// File: rtl/rom_burst_arbiter.sv
// Round-robin arbiter sharing one combinational ROM between two
// burst requesters; streams registered words with valid/last/id.
module rom_burst_arbiter #(
  parameter int AW = 4,
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req0,
  input  logic [AW-1:0] addr0,
  input  logic [AW-1:0] len0,
  input  logic          req1,
  input  logic [AW-1:0] addr1,
  input  logic [AW-1:0] len1,
  output logic          gnt0,
  output logic          gnt1,
  output logic [AW-1:0] rom_addr,
  input  logic [DW-1:0] rom_data,
  output logic          rd_valid,
  output logic [DW-1:0] rd_data,
  output logic          rd_last,
  output logic          rd_id,
  output logic          busy
);

  typedef enum logic {IDLE, BURST} state_t;

  state_t        state, state_d;
  logic [AW-1:0] cnt;
  logic          id;
  logic          last_id;
  logic          g0, g1;

  always_comb begin
    g0      = 1'b0;
    g1      = 1'b0;
    state_d = state;
    case (state)
      IDLE: begin
        // on a tie, the requester not served last wins
        unique case (1'b1)
          req0 && (!req1 || last_id): g0 = 1'b1;
          req1 && (!req0 || !last_id): g1 = 1'b1;
          default: ;
        endcase
        if (g0 || g1) state_d = BURST;
      end
      BURST: begin
        if (cnt == '0) state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gnt0     <= 1'b0;
      gnt1     <= 1'b0;
      rom_addr <= '0;
      rd_valid <= 1'b0;
      rd_data  <= '0;
      rd_last  <= 1'b0;
      rd_id    <= 1'b0;
      cnt      <= '0;
      id       <= 1'b0;
      last_id  <= 1'b1;
    end else begin
      gnt0 <= g0;
      gnt1 <= g1;
      if (state == IDLE) begin
        rd_valid <= 1'b0;
        rd_last  <= 1'b0;
        if (g0) begin
          rom_addr <= addr0;
          cnt      <= len0;
          id       <= 1'b0;
          last_id  <= 1'b0;
        end else if (g1) begin
          rom_addr <= addr1;
          cnt      <= len1;
          id       <= 1'b1;
          last_id  <= 1'b1;
        end
      end else begin
        rd_data  <= rom_data;
        rd_valid <= 1'b1;
        rd_id    <= id;
        rom_addr <= rom_addr + AW'(1);
        if (cnt == '0) begin
          rd_last <= 1'b1;
        end else begin
          cnt     <= cnt - AW'(1);
          rd_last <= 1'b0;
        end
      end
    end
  end

  assign busy = (state == BURST);

endmodule

// File: tb/tb_rom_burst_arbiter.sv
// Directed bench for rom_burst_arbiter.
// ROM model: ROM[i] = {i, i}.
module tb_rom_burst_arbiter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req0, req1;
  logic [3:0] addr0, len0, addr1, len1;
  logic       gnt0, gnt1;
  logic [3:0] rom_addr;
  logic [7:0] rom_data;
  logic       rd_valid, rd_last, rd_id, busy;
  logic [7:0] rd_data;

  int vectors = 0;
  int errs    = 0;

  always #5 clk = ~clk;

  assign rom_data = {rom_addr, rom_addr};

  rom_burst_arbiter #(.AW(4), .DW(8)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req0     (req0),
    .addr0    (addr0),
    .len0     (len0),
    .req1     (req1),
    .addr1    (addr1),
    .len1     (len1),
    .gnt0     (gnt0),
    .gnt1     (gnt1),
    .rom_addr (rom_addr),
    .rom_data (rom_data),
    .rd_valid (rd_valid),
    .rd_data  (rd_data),
    .rd_last  (rd_last),
    .rd_id    (rd_id),
    .busy     (busy)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] want);
    vectors++;
    if (obs !== want) begin
      errs++;
      $display("FAIL %s: got %0h want %0h", tag, obs, want);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, " gnt0"}, gnt0, 0);
    chk({tag, " gnt1"}, gnt1, 0);
    chk({tag, " addr"}, rom_addr, 0);
    chk({tag, " vld"}, rd_valid, 0);
    chk({tag, " data"}, rd_data, 0);
    chk({tag, " last"}, rd_last, 0);
    chk({tag, " id"}, rd_id, 0);
    chk({tag, " busy"}, busy, 0);
  endtask

  // check a single beat k of a burst starting at a
  task automatic chk_beat(input string tag, input logic r,
                          input logic [3:0] a, input int k,
                          input int l);
    logic [3:0] w;
    w = a + 4'(k);
    chk({tag, " vld"}, rd_valid, 1);
    chk({tag, " data"}, rd_data, {w, w});
    chk({tag, " last"}, rd_last, (k == l));
    chk({tag, " id"}, rd_id, r);
    chk({tag, " busy"}, busy, (k != l));
  endtask

  task automatic run_burst(input string tag, input logic r,
                           input logic [3:0] a,
                           input logic [3:0] l);
    logic [3:0] ea;
    if (r) begin
      req1 = 1; addr1 = a; len1 = l;
    end else begin
      req0 = 1; addr0 = a; len0 = l;
    end
    @(negedge clk);
    chk({tag, " gnt0"}, gnt0, !r);
    chk({tag, " gnt1"}, gnt1, r);
    chk({tag, " busy0"}, busy, 1);
    chk({tag, " gvld"}, rd_valid, 0);
    req0 = 0; req1 = 0;
    for (int k = 0; k <= int'(l); k++) begin
      ea = a + 4'(k);
      chk({tag, " raddr"}, rom_addr, ea);
      @(negedge clk);
      chk_beat(tag, r, a, k, int'(l));
      chk({tag, " nogn"}, gnt0 | gnt1, 0);
    end
    @(negedge clk);
    chk({tag, " idle vld"}, rd_valid, 0);
    chk({tag, " idle last"}, rd_last, 0);
    chk({tag, " idle busy"}, busy, 0);
  endtask

  initial begin
    rst_n = 0;
    req0 = 0; req1 = 0;
    addr0 = 0; len0 = 0; addr1 = 0; len1 = 0;
    #1;
    chk_zero("reset");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    chk_zero("post-reset");

    // 1: single word
    run_burst("t1", 0, 4'd2, 4'd0);

    // 2: wrap-around burst
    run_burst("t2", 1, 4'd14, 4'd3);

    // 3: both held high, round robin
    req0 = 1; addr0 = 4'd3; len0 = 4'd1;
    req1 = 1; addr1 = 4'd8; len1 = 4'd1;
    for (int n = 0; n < 4; n++) begin
      logic r;
      logic [3:0] a;
      r = n[0];
      a = r ? 4'd8 : 4'd3;
      @(negedge clk);
      chk("t3 gnt0", gnt0, !r);
      chk("t3 gnt1", gnt1, r);
      chk("t3 gap", rd_valid, 0);
      for (int k = 0; k < 2; k++) begin
        @(negedge clk);
        chk_beat("t3", r, a, k, 1);
      end
      if (n == 3) begin
        req0 = 0; req1 = 0;
      end
    end
    @(negedge clk);
    chk("t3 end vld", rd_valid, 0);
    chk("t3 end busy", busy, 0);

    // 4: req1 during long burst of requester 0
    req0 = 1; addr0 = 4'd5; len0 = 4'd15;
    @(negedge clk);
    chk("t4 gnt0", gnt0, 1);
    req0 = 0;
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      chk_beat("t4", 0, 4'd5, k, 15);
      chk("t4 nognt1", gnt1, 0);
      if (k == 3) begin
        req1 = 1; addr1 = 4'd9; len1 = 4'd0;
      end
    end
    @(negedge clk);
    chk("t4 gnt1", gnt1, 1);
    chk("t4 gap", rd_valid, 0);
    req1 = 0;
    @(negedge clk);
    chk_beat("t4b", 1, 4'd9, 0, 0);
    @(negedge clk);
    chk("t4 idle", busy, 0);

    // 5: reset on the 5th beat
    req0 = 1; addr0 = 4'd0; len0 = 4'd15;
    @(negedge clk);
    chk("t5 gnt0", gnt0, 1);
    req0 = 0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk_beat("t5", 0, 4'd0, k, 15);
    end
    rst_n = 0;
    #1;
    chk_zero("t5 async");
    @(negedge clk);
    rst_n = 1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk_zero("t5 after");
    end

    // 6: full 16-word burst from 0
    run_burst("t6", 0, 4'd0, 4'd15);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, errs);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

endmodule
